mc_controller: RTL and testbench

Multicycle successor to the single-cycle ARM controller: a Moore FSM plus registered condition logic that sequences fetch, decode, execute, memory and writeback over several cycles on a shared memory port. It adds a memory-ready handshake with a parametrised timeout and sticky fault state. It sits in the multicycle datapath top, driving the PC, IR, memory, register-file and ALU-mux controls.

---
 rtl/mc_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mc_controller                                                 |
// | Purpose  : Multicycle ARM control unit. A Moore FSM sequences fetch,     |
// |            decode, execute, memory and writeback on a shared memory      |
// |            port. A memory-ready handshake with a wait-cycle timeout      |
// |            drives a sticky FAULT state that only reset can leave.        |
// | Ports    : clk, rst (async, active-low)                                  |
// |            Cond/Op/Funct/Rd      - instruction fields from the IR         |
// |            ALUFlags              - {N,Z,C,V} from the ALU                 |
// |            MemReady              - memory completes access this cycle     |
// |            PCWrite/IRWrite/RegWrite/MemWrite - write strobes             |
// |            AdrSrc/ALUSrcA/ALUSrcB/ResultSrc/ImmSrc/RegSrc/ALUControl     |
// |                                  - datapath mux and ALU selects           |
// |            Fault                 - sticky memory timeout indication       |
// | Options  : MC_CMP_EN - decode cmd 1010 as CMP (SUB, flags only, no       |
// |            register write). Undefined: cmd 1010 behaves as ADD.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mc_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic       Fault
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_EXECR  = 4'd6;
    localparam logic [3:0] c_EXECI  = 4'd7;
    localparam logic [3:0] c_ALUWB  = 4'd8;
    localparam logic [3:0] c_BRANCH = 4'd9;
    localparam logic [3:0] c_FAULT  = 4'd10;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       flags_q, flags_d;
    logic             condex_q, condex_d;

    logic             cond_ex;
    logic [1:0]       alu_ctl;
    logic [1:0]       flag_w;
    logic             no_write;
    logic             wait_st;

    // Rd is part of the instruction bus but R15 writes are not treated specially.
    logic unused_rd;
    assign unused_rd = ^Rd;

    // ARM condition evaluation on the registered {N,Z,C,V}.
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Data-processing decode: ALU op, flag-write enables and write suppression.
    always_comb begin
        alu_ctl  = 2'b00;
        no_write = 1'b0;
        case (Funct[4:1])
            4'b0100: alu_ctl = 2'b00;
            4'b0010: alu_ctl = 2'b01;
            4'b0000: alu_ctl = 2'b10;
            4'b1100: alu_ctl = 2'b11;
`ifdef MC_CMP_EN
            4'b1010: alu_ctl = 2'b01;
`endif
            default: alu_ctl = 2'b00;
        endcase
        // C and V are only meaningful for arithmetic operations.
        flag_w[1] = Funct[0];
        flag_w[0] = Funct[0] & ((alu_ctl == 2'b00) | (alu_ctl == 2'b01));
`ifdef MC_CMP_EN
        if (Funct[4:1] == 4'b1010) begin
            flag_w   = 2'b11;
            no_write = 1'b1;
        end
`endif
    end

    assign wait_st = (state_q == c_FETCH) | (state_q == c_MEMRD) | (state_q == c_MEMWR);

    // Next-state, wait counter, flags and latched condition.
    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        condex_d = condex_q;
        case (state_q)
            c_FETCH:  if (MemReady) state_d = c_DECODE;
            c_DECODE: begin
                condex_d = cond_ex;
                case (Op)
                    2'b01:   state_d = c_MEMADR;
                    2'b00:   state_d = Funct[5] ? c_EXECI : c_EXECR;
                    2'b10:   state_d = c_BRANCH;
                    default: state_d = c_FETCH;
                endcase
            end
            c_MEMADR: state_d = Funct[0] ? c_MEMRD : c_MEMWR;
            c_MEMRD:  if (MemReady) state_d = c_MEMWB;
            c_MEMWB:  state_d = c_FETCH;
            c_MEMWR:  if (MemReady) state_d = c_FETCH;
            c_EXECR, c_EXECI: begin
                state_d = c_ALUWB;
                if (condex_q & flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
                if (condex_q & flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
            end
            c_ALUWB:  state_d = c_FETCH;
            c_BRANCH: state_d = c_FETCH;
            c_FAULT:  state_d = c_FAULT;
            default:  state_d = c_FETCH;
        endcase

        // The timeout overrides "stay": the last not-ready cycle goes to FAULT.
        cnt_d = '0;
        if (wait_st && !MemReady) begin
            if (cnt_q == c_CNT_LAST) begin
                state_d = c_FAULT;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= c_FETCH;
            cnt_q    <= '0;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    // Moore outputs (strobes also qualified by MemReady in wait states).
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        Fault      = 1'b0;
        case (state_q)
            c_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            c_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            c_MEMADR: ALUSrcB = 2'b01;
            c_MEMRD:  AdrSrc  = 1'b1;
            c_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = condex_q;
            end
            c_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = condex_q;
            end
            c_EXECR:  ALUControl = alu_ctl;
            c_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_ctl;
            end
            c_ALUWB:  RegWrite = condex_q & ~no_write;
            c_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = condex_q;
            end
            c_FAULT:  Fault = 1'b1;
            default: ;
        endcase
        // Reset holds the FSM in FETCH, but no write may escape while it is held.
        if (!rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mc_controller                                              |
// | Purpose  : Self-checking bench for mc_controller. Instructions are       |
// |            expanded into their expected per-cycle output sequence from   |
// |            the instruction semantics; one compare process checks every   |
// |            cycle. Directed cases pin the expectations with literals.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mc_controller;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = $clog2(MEM_TIMEOUT + 1);

    typedef struct packed {
        logic       pcw, irw, rw, mw, adr, asa;
        logic [1:0] asb, rsrc, imm, regsrc, aluc;
        logic       flt;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] Cond = 4'd0;
    logic [1:0] Op = 2'd0;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic [3:0] ALUFlags = 4'd0;
    logic       MemReady = 1'b0;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, Fault;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    always #5 clk = ~clk;

    mc_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .Fault(Fault)
    );

    int         checks = 0;
    int         errors = 0;
    int         ncyc = 0;
    int         pre_fault = 0;
    bit         exp_valid = 1'b0;
    out_t       exp_o;
    out_t       act;
    out_t       hist[$];
    logic [3:0] mflags = 4'b0000;   // architectural flags as the model sees them

    // Single compare process: every meaningful cycle, DUT outputs vs model.
    always @(negedge clk) begin
        if (exp_valid) begin
            act = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
                   ResultSrc, ImmSrc, RegSrc, ALUControl, Fault};
            hist.push_back(act);
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL outputs cycle %0d actual=%b required=%b (pcw irw rw mw adr asa asb rsrc imm regsrc aluc flt)",
                         ncyc, act, exp_o);
            end
        end
    end

    task automatic pin(input string name, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, a, e);
        end
    endtask

    function automatic out_t mk(logic pcw, logic irw, logic rw, logic mw, logic adr,
                                logic asa, logic [1:0] asb, logic [1:0] rsrc,
                                logic [1:0] aluc, logic flt);
        out_t o;
        o.pcw = pcw; o.irw = irw; o.rw = rw; o.mw = mw; o.adr = adr; o.asa = asa;
        o.asb = asb; o.rsrc = rsrc; o.aluc = aluc; o.flt = flt;
        o.imm = Op;
        o.regsrc = {(Op == 2'b01), (Op == 2'b10)};
        return o;
    endfunction

    function automatic logic cond_true(logic [3:0] c, logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cy;         4'h3: return !cy;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return cy && !z;   4'h9: return !cy || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] m_aluc(logic [3:0] cmd);
        if (cmd == 4'b0010) return 2'b01;
        if (cmd == 4'b0000) return 2'b10;
        if (cmd == 4'b1100) return 2'b11;
`ifdef MC_CMP_EN
        if (cmd == 4'b1010) return 2'b01;
`endif
        return 2'b00;
    endfunction

    function automatic logic [1:0] m_flagw(logic [5:0] f);
        logic arith;
`ifdef MC_CMP_EN
        if (f[4:1] == 4'b1010) return 2'b11;
`endif
        arith = (m_aluc(f[4:1]) == 2'b00) || (m_aluc(f[4:1]) == 2'b01);
        return {f[0], f[0] & arith};
    endfunction

    function automatic logic m_nowrite(logic [3:0] cmd);
`ifdef MC_CMP_EN
        return cmd == 4'b1010;
`else
        return cmd == 4'b1111 && cmd != 4'b1111;
`endif
    endfunction

    // One clock cycle: drive at posedge+1, checked at negedge, return at next posedge+1.
    task automatic cycle(input out_t e, input logic rdy);
        MemReady  = rdy;
        exp_o     = e;
        exp_valid = 1'b1;
        ncyc++;
        @(negedge clk); #1;
        @(posedge clk); #1;
    endtask

    // Memory handshake: nwait not-ready cycles, then ready, unless the timeout hits.
    task automatic access(input out_t e_wait, input out_t e_done, input int nwait,
                          output bit faulted);
        faulted = 1'b0;
        for (int i = 0; ; i++) begin
            if (i == MEM_TIMEOUT) begin
                faulted = 1'b1;
                return;
            end
            if (i == nwait) begin
                cycle(e_done, 1'b1);
                return;
            end
            cycle(e_wait, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        MemReady = 1'b1;
        exp_o = mk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 0);
        exp_valid = 1'b1;
        @(negedge clk); #1;
        pin("reset_fault", int'(Fault), 0);
        pin("reset_strobes", int'({PCWrite, IRWrite, RegWrite, MemWrite}), 0);
        @(posedge clk); #1;
        exp_valid = 1'b0;
        rst = 1'b1;
        MemReady = 1'b0;
        mflags = 4'b0000;
    endtask

    task automatic do_fault();
        int n;
        pre_fault = hist.size();
        n = 2 + int'($urandom_range(0, 3));
        for (int i = 0; i < n; i++) begin
            Op = 2'($urandom);
            cycle(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1), 1'($urandom_range(0, 1)));
        end
        pin("fault_sticky", int'(hist[hist.size() - 1].flt), 1);
        do_reset();
    endtask

    task automatic instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                         input logic [3:0] af, input int nwf, input int nwm);
        bit         flt;
        logic       ce;
        logic [1:0] fw;
        Cond = c; Op = op; Funct = f; ALUFlags = af; Rd = 4'($urandom);
        hist.delete();
        access(mk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 0),
               mk(1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 0), nwf, flt);
        if (flt) begin do_fault(); return; end
        ce = cond_true(c, mflags);
        cycle(mk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 0), 1'($urandom_range(0, 1)));
        case (op)
            2'b01: begin
                cycle(mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0), 1'($urandom_range(0, 1)));
                if (f[0]) begin
                    access(mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0),
                           mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0), nwm, flt);
                    if (flt) begin do_fault(); return; end
                    cycle(mk(0, 0, ce, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0), 1'($urandom_range(0, 1)));
                end else begin
                    access(mk(0, 0, 0, ce, 1, 0, 2'b00, 2'b00, 2'b00, 0),
                           mk(0, 0, 0, ce, 1, 0, 2'b00, 2'b00, 2'b00, 0), nwm, flt);
                    if (flt) begin do_fault(); return; end
                end
            end
            2'b00: begin
                cycle(mk(0, 0, 0, 0, 0, 0, f[5] ? 2'b01 : 2'b00, 2'b00, m_aluc(f[4:1]), 0),
                      1'($urandom_range(0, 1)));
                fw = m_flagw(f);
                if (ce && fw[1]) mflags[3:2] = af[3:2];
                if (ce && fw[0]) mflags[1:0] = af[1:0];
                cycle(mk(0, 0, ce && !m_nowrite(f[4:1]), 0, 0, 0, 2'b00, 2'b00, 2'b00, 0),
                      1'($urandom_range(0, 1)));
            end
            2'b10: cycle(mk(ce, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0), 1'($urandom_range(0, 1)));
            default: ;
        endcase
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int any_mw;
        int nwf, nwm;
        logic [5:0] f;
        logic [3:0] cmds[6];
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
        cmds[3] = 4'b1100; cmds[4] = 4'b1010; cmds[5] = 4'b0111;

        @(posedge clk); #1;
        do_reset();

        // ADD R1, register form: 4 cycles, write in the last one.
        instr(4'hE, 2'b00, 6'b001000, 4'b0000, 0, 0);
        pin("add_len", hist.size(), 4);
        pin("add_aluc", int'(hist[2].aluc), 0);
        pin("add_regwrite", int'(hist[3].rw), 1);

        // SUBS sets Z, then BEQ is taken.
        instr(4'hE, 2'b00, 6'b000101, 4'b0100, 0, 0);
        pin("subs_aluc", int'(hist[2].aluc), 1);
        instr(4'h0, 2'b10, 6'b000000, 4'b0000, 0, 0);
        pin("beq_len", hist.size(), 3);
        pin("beq_pcwrite", int'(hist[2].pcw), 1);

        // LDR with three not-ready cycles in MEMRD.
        instr(4'hE, 2'b01, 6'b011001, 4'b0000, 0, 3);
        pin("ldr_len", hist.size(), 8);
        pin("ldr_regwrite", int'(hist[7].rw), 1);

        // STRNE with Z=1: no memory write anywhere.
        instr(4'h1, 2'b01, 6'b011000, 4'b0000, 0, 2);
        any_mw = 0;
        foreach (hist[i]) any_mw |= int'(hist[i].mw);
        pin("strne_memwrite", any_mw, 0);
        pin("strne_len", hist.size(), 6);

        // Fetch never ready: fault after exactly MEM_TIMEOUT cycles.
        instr(4'hE, 2'b00, 6'b001000, 4'b0000, 1000, 0);
        pin("timeout_cycles", pre_fault, 16);

        // Ready on the counter's final cycle: the access completes.
        instr(4'hE, 2'b11, 6'b000000, 4'b0000, MEM_TIMEOUT - 1, 0);
        pin("last_cycle_ready_fault", int'(hist[hist.size() - 1].flt), 0);

        // cmd 1010 with S=1, ALUFlags 0110; flags then drive a CS branch.
        instr(4'hE, 2'b00, 6'b010101, 4'b0110, 0, 0);
`ifdef MC_CMP_EN
        pin("cmp_aluc", int'(hist[2].aluc), 1);
        pin("cmp_regwrite", int'(hist[3].rw), 0);
`else
        pin("cmp_aluc", int'(hist[2].aluc), 0);
        pin("cmp_regwrite", int'(hist[3].rw), 1);
`endif
        instr(4'h2, 2'b10, 6'b000000, 4'b0000, 0, 0);
        pin("bcs_pcwrite", int'(hist[2].pcw), 1);

        // Randomized instruction stream.
        for (int k = 0; k < 300; k++) begin
            f = 6'($urandom);
            f[4:1] = cmds[$urandom_range(0, 5)];
            nwf = int'($urandom_range(0, 3));
            nwm = int'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) nwf = MEM_TIMEOUT - 1;
            if ($urandom_range(0, 29) == 0) nwm = MEM_TIMEOUT - 1;
            if ($urandom_range(0, 59) == 0) nwf = MEM_TIMEOUT + 3;
            if ($urandom_range(0, 59) == 0) nwm = MEM_TIMEOUT + 3;
            instr(4'($urandom), 2'($urandom), f, 4'($urandom), nwf, nwm);
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        exp_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
